lcd_write_arbiter: RTL

Shares the single LCD display controller between two byte producers: the MiniAlu `LCD` instruction path (CPU) and an auxiliary requester (debug/status logic). Each requester gets a small FIFO. A round-robin arbiter pops one byte at a time and drives the controller's `iData`/`iData_Ready` handshake. It then tracks the controller's `oReadyForData` through busy and back to idle before issuing the next byte. The block sits between the ALU/aux logic and `Module_LCD_Control`.

---
 rtl/lcd_write_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD controller between a CPU and an aux byte
// producer, each behind a small FIFO, with a bounded wait for the controller to ack.
module lcd_write_arbiter #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iCpuData,
  input  logic       iCpuValid,
  output logic       oCpuReady,
  input  logic [7:0] iAuxData,
  input  logic       iAuxValid,
  output logic       oAuxReady,
  input  logic       iLcdReady,
  output logic [7:0] oLcdData,
  output logic       oLcdDataReady,
  output logic       oGrant,
  output logic       oBusy,
  output logic       oTimeoutErr,
  input  logic       iClearErr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [7:0]    cpu_mem_q [DEPTH];
  logic [7:0]    aux_mem_q [DEPTH];
  logic [PW-1:0] cpu_wr_q, cpu_wr_d, cpu_rd_q, cpu_rd_d;
  logic [PW-1:0] aux_wr_q, aux_wr_d, aux_rd_q, aux_rd_d;
  logic [CW-1:0] cpu_cnt_q, cpu_cnt_d, aux_cnt_q, aux_cnt_d;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          stb_q, stb_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic cpu_push, aux_push, cpu_pop, aux_pop;
  logic cpu_ne, aux_ne, sel, set_err;

  // Ready is decoded from registered counts only, so a pop cannot admit a push into a full FIFO.
  assign oCpuReady = (cpu_cnt_q < CW'(DEPTH));
  assign oAuxReady = (aux_cnt_q < CW'(DEPTH));

  assign oLcdData      = data_q;
  assign oLcdDataReady = stb_q;
  assign oGrant        = grant_q;
  assign oBusy         = busy_q;
  assign oTimeoutErr   = err_q;

  // Arbitration and controller handshake FSM.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    stb_d   = 1'b0;
    grant_d = grant_q;
    err_d   = err_q;
    cpu_pop = 1'b0;
    aux_pop = 1'b0;
    set_err = 1'b0;
    cpu_ne  = (cpu_cnt_q != '0);
    aux_ne  = (aux_cnt_q != '0);
    sel     = (cpu_ne && aux_ne) ? ~grant_q : aux_ne;

    case (state_q)
      ST_IDLE: begin
        if (iLcdReady && (cpu_ne || aux_ne)) begin
          data_d  = sel ? aux_mem_q[aux_rd_q] : cpu_mem_q[cpu_rd_q];
          cpu_pop = ~sel;
          aux_pop = sel;
          grant_d = sel;
          stb_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!iLcdReady) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (iLcdReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (set_err) begin
      err_d = 1'b1;
    end else if (iClearErr) begin
      err_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    cpu_push  = iCpuValid && oCpuReady;
    aux_push  = iAuxValid && oAuxReady;
    cpu_wr_d  = cpu_wr_q + PW'(cpu_push);
    cpu_rd_d  = cpu_rd_q + PW'(cpu_pop);
    aux_wr_d  = aux_wr_q + PW'(aux_push);
    aux_rd_d  = aux_rd_q + PW'(aux_pop);
    cpu_cnt_d = cpu_cnt_q + CW'(cpu_push) - CW'(cpu_pop);
    aux_cnt_d = aux_cnt_q + CW'(aux_push) - CW'(aux_pop);
  end

  always_ff @(posedge Clock) begin
    if (cpu_push) cpu_mem_q[cpu_wr_q] <= iCpuData;
    if (aux_push) aux_mem_q[aux_wr_q] <= iAuxData;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cpu_wr_q  <= '0;
      cpu_rd_q  <= '0;
      cpu_cnt_q <= '0;
      aux_wr_q  <= '0;
      aux_rd_q  <= '0;
      aux_cnt_q <= '0;
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      data_q    <= 8'h00;
      stb_q     <= 1'b0;
      grant_q   <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cpu_wr_q  <= cpu_wr_d;
      cpu_rd_q  <= cpu_rd_d;
      cpu_cnt_q <= cpu_cnt_d;
      aux_wr_q  <= aux_wr_d;
      aux_rd_q  <= aux_rd_d;
      aux_cnt_q <= aux_cnt_d;
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      stb_q     <= stb_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

endmodule
